// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file read side.
package regfile_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;
    localparam int ZERO_REG   = 31;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [63:0]           reg_word_t;

    // EMPTY: no response outstanding. FULL: a response is being presented.
    typedef enum logic {
        RSP_EMPTY = 1'b0,
        RSP_FULL  = 1'b1
    } rsp_state_t;

    // True when an address names the hard-wired zero register.
    function automatic logic is_zero_addr(reg_addr_t addr, int zeroReg);
        return addr == reg_addr_t'(zeroReg);
    endfunction

endpackage

// File: rtl/regfile_read_port_operand_select.sv
// One operand lookup: array mux, same-cycle write bypass and zero-register forcing.
module operand_select
    import regfile_pkg::*;
#(
    parameter int WIDTH     = 64,
    parameter int NREGS     = 32,
    parameter int ZERO_ADDR = 31
) (
    input  logic [NREGS-1:0][WIDTH-1:0] regs_i,
    input  logic [NREGS-1:0]            wr_i,
    input  logic [WIDTH-1:0]            wr_data_i,
    input  reg_addr_t                   addr_i,
    output logic [WIDTH-1:0]            operand_o,
    output logic                        bypass_hit_o
);

    logic isZero;

    assign isZero       = is_zero_addr(addr_i, ZERO_ADDR);
    assign bypass_hit_o = !isZero && wr_i[addr_i];

    // Zero register wins over everything, then the in-flight write, then the array.
    always_comb begin
        operand_o = regs_i[addr_i];
        if (isZero) begin
            operand_o = '0;
        end else if (wr_i[addr_i]) begin
            operand_o = wr_data_i;
        end
    end

endmodule

// File: rtl/regfile_read_port.sv
// Two-operand read port with request/response handshakes, write bypass and
// stall-time refresh of the held operands.
module regfile_read_port #(
    parameter int WIDTH    = 64,
    parameter int NREGS    = 32,
    parameter int ZERO_REG = 31
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NREGS-1:0][WIDTH-1:0] regs,
    input  logic [NREGS-1:0]            wr,
    input  logic [WIDTH-1:0]            wr_data,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  regfile_pkg::reg_addr_t      ra,
    input  regfile_pkg::reg_addr_t      rb,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [WIDTH-1:0]            da,
    output logic [WIDTH-1:0]            db
);

    import regfile_pkg::*;

    rsp_state_t       state_q, state_d;
    reg_addr_t        raHeld_q, raHeld_d;
    reg_addr_t        rbHeld_q, rbHeld_d;
    logic [WIDTH-1:0] da_q, da_d;
    logic [WIDTH-1:0] db_q, db_d;

    logic             accept;
    logic             complete;
    logic             stall;
    reg_addr_t        selA, selB;
    logic [WIDTH-1:0] opA, opB;
    logic             hitA, hitB;

    assign rsp_valid = (state_q == RSP_FULL);
    assign req_ready = !rsp_valid || rsp_ready;
    assign accept    = req_valid && req_ready;
    assign complete  = rsp_valid && rsp_ready;
    assign stall     = rsp_valid && !rsp_ready;

    // A new request looks up its own addresses; otherwise the lookups watch the
    // held addresses so a stalled response can pick up later writes.
    assign selA = accept ? ra : raHeld_q;
    assign selB = accept ? rb : rbHeld_q;

    operand_select #(
        .WIDTH     (WIDTH),
        .NREGS     (NREGS),
        .ZERO_ADDR (ZERO_REG)
    ) u_select_a (
        .regs_i       (regs),
        .wr_i         (wr),
        .wr_data_i    (wr_data),
        .addr_i       (selA),
        .operand_o    (opA),
        .bypass_hit_o (hitA)
    );

    operand_select #(
        .WIDTH     (WIDTH),
        .NREGS     (NREGS),
        .ZERO_ADDR (ZERO_REG)
    ) u_select_b (
        .regs_i       (regs),
        .wr_i         (wr),
        .wr_data_i    (wr_data),
        .addr_i       (selB),
        .operand_o    (opB),
        .bypass_hit_o (hitB)
    );

    // Next state: load on accept, drain on complete, refresh on stall when written.
    always_comb begin
        state_d  = state_q;
        raHeld_d = raHeld_q;
        rbHeld_d = rbHeld_q;
        da_d     = da_q;
        db_d     = db_q;
        if (accept) begin
            state_d  = RSP_FULL;
            raHeld_d = ra;
            rbHeld_d = rb;
            da_d     = opA;
            db_d     = opB;
        end else if (complete) begin
            state_d = RSP_EMPTY;
        end else if (stall) begin
            if (hitA) begin
                da_d = opA;
            end
            if (hitB) begin
                db_d = opB;
            end
        end
    end

    // Response state, held addresses and operand registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= RSP_EMPTY;
            raHeld_q <= '0;
            rbHeld_q <= '0;
            da_q     <= '0;
            db_q     <= '0;
        end else begin
            state_q  <= state_d;
            raHeld_q <= raHeld_d;
            rbHeld_q <= rbHeld_d;
            da_q     <= da_d;
            db_q     <= db_d;
        end
    end

    assign da = da_q;
    assign db = db_q;

endmodule

// File: tb/tb_regfile_read_port.sv
// Randomised and directed bench for regfile_read_port with a queue-based scoreboard.
module tb_regfile_read_port;

    import regfile_pkg::*;

    localparam int W = 64;

    logic                clk = 1'b0;
    logic                reset;
    logic [31:0][W-1:0]  regs;
    logic [31:0]         wr;
    logic [W-1:0]        wrData;
    logic                reqValid;
    logic                reqReady;
    reg_addr_t           ra;
    reg_addr_t           rb;
    logic                rspValid;
    logic                rspReady;
    logic [W-1:0]        da;
    logic [W-1:0]        db;

    int testsRun    = 0;
    int testsFailed = 0;

    typedef struct {
        reg_addr_t a;
        reg_addr_t b;
        reg_word_t da;
        reg_word_t db;
    } rsp_t;

    rsp_t      expQ[$];
    rsp_t      frontEntry;
    reg_word_t lastDa;
    reg_word_t lastDb;

    always #5 clk = ~clk;

    regfile_read_port #(
        .WIDTH    (W),
        .NREGS    (32),
        .ZERO_REG (31)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .regs      (regs),
        .wr        (wr),
        .wr_data   (wrData),
        .req_valid (reqValid),
        .req_ready (reqReady),
        .ra        (ra),
        .rb        (rb),
        .rsp_valid (rspValid),
        .rsp_ready (rspReady),
        .da        (da),
        .db        (db)
    );

    // Value an address should read right now: zero register, pending write, or array.
    function automatic reg_word_t refOperand(reg_addr_t a);
        if (a == 5'd31) return '0;
        if (wr[a]) return wrData;
        return regs[a];
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Drive one cycle of inputs just after the rising edge; the array absorbs last cycle's write.
    task automatic applyStimulus(input logic v, input reg_addr_t a, input reg_addr_t b,
                                 input logic rr, input logic [31:0] w, input reg_word_t wd);
        @(posedge clk);
        #1;
        for (int i = 0; i < 31; i++) begin
            if (wr[i]) regs[i] = wrData;
        end
        reqValid = v;
        ra       = a;
        rb       = b;
        rspReady = rr;
        wr       = w;
        wrData   = wd;
    endtask

    // Monitor: compares what the DUT presents against the head of the scoreboard.
    always @(negedge clk) begin
        if (reset) begin
            expQ.delete();
            lastDa = '0;
            lastDb = '0;
        end else begin
            checkOutput("rsp_valid", 64'(rspValid), 64'(expQ.size() != 0));
            checkOutput("req_ready", 64'(reqReady), 64'(expQ.size() == 0 || rspReady));
            if (expQ.size() != 0) begin
                checkOutput("da", da, expQ[0].da);
                checkOutput("db", db, expQ[0].db);
                if (rspReady) begin
                    lastDa = expQ[0].da;
                    lastDb = expQ[0].db;
                    void'(expQ.pop_front());
                end
            end else begin
                checkOutput("da_hold", da, lastDa);
                checkOutput("db_hold", db, lastDb);
            end
        end
    end

    // Reference model: after the monitor, decide what the coming edge does.
    always @(negedge clk) begin
        #1;
        if (!reset) begin
            if (expQ.size() != 0) begin
                frontEntry = expQ[0];
                if (frontEntry.a != 5'd31 && wr[frontEntry.a]) frontEntry.da = wrData;
                if (frontEntry.b != 5'd31 && wr[frontEntry.b]) frontEntry.db = wrData;
                expQ[0] = frontEntry;
            end else if (reqValid) begin
                expQ.push_back('{a: ra, b: rb, da: refOperand(ra), db: refOperand(rb)});
            end
        end
    end

    initial begin
        reset    = 1'b1;
        reqValid = 1'b0;
        ra       = '0;
        rb       = '0;
        rspReady = 1'b0;
        wr       = '0;
        wrData   = '0;
        for (int i = 0; i < 32; i++) regs[i] = {$urandom, $urandom};
        #1;
        checkOutput("reset_rsp_valid", 64'(rspValid), 64'd0);
        checkOutput("reset_req_ready", 64'(reqReady), 64'd1);
        checkOutput("reset_da", da, 64'd0);
        checkOutput("reset_db", db, 64'd0);
        #12;
        reset = 1'b0;

        // Plain array read
        regs[3] = 64'h1234;
        regs[7] = 64'hABCD;
        applyStimulus(1'b1, 5'd3, 5'd7, 1'b1, 32'h0, 64'h0);
        applyStimulus(1'b0, 5'd0, 5'd0, 1'b1, 32'h0, 64'h0);
        @(negedge clk);
        checkOutput("t2_valid", 64'(rspValid), 64'd1);
        checkOutput("t2_da", da, 64'h1234);
        checkOutput("t2_db", db, 64'hABCD);

        // Bypass and zero register, including a write aimed at register 31
        regs[5] = 64'h0;
        applyStimulus(1'b1, 5'd5, 5'd31, 1'b1, 32'h20, 64'hFF);
        applyStimulus(1'b1, 5'd5, 5'd31, 1'b1, 32'h8000_0000, 64'hFF);
        @(negedge clk);
        checkOutput("t3_bypass_da", da, 64'hFF);
        checkOutput("t3_xzr_db", db, 64'h0);
        applyStimulus(1'b0, 5'd0, 5'd0, 1'b1, 32'h0, 64'h0);
        @(negedge clk);
        checkOutput("t3_xzr_wr31_db", db, 64'h0);

        // Back-to-back requests at full throughput
        applyStimulus(1'b1, 5'd1, 5'd2, 1'b1, 32'h0, 64'h0);
        @(negedge clk);
        checkOutput("t4_ready0", 64'(reqReady), 64'd1);
        applyStimulus(1'b1, 5'd3, 5'd4, 1'b1, 32'h0, 64'h0);
        @(negedge clk);
        checkOutput("t4_ready1", 64'(reqReady), 64'd1);
        checkOutput("t4_da1", da, regs[1]);
        checkOutput("t4_db1", db, regs[2]);
        applyStimulus(1'b1, 5'd5, 5'd6, 1'b1, 32'h0, 64'h0);
        @(negedge clk);
        checkOutput("t4_ready2", 64'(reqReady), 64'd1);
        checkOutput("t4_da2", da, regs[3]);
        checkOutput("t4_db2", db, regs[4]);
        applyStimulus(1'b0, 5'd0, 5'd0, 1'b1, 32'h0, 64'h0);
        @(negedge clk);
        checkOutput("t4_valid3", 64'(rspValid), 64'd1);
        checkOutput("t4_da3", da, regs[5]);
        checkOutput("t4_db3", db, regs[6]);

        // Stall with a write to the held register in the middle
        applyStimulus(1'b1, 5'd9, 5'd9, 1'b1, 32'h0, 64'h0);
        applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 32'h0, 64'h0);
        @(negedge clk);
        checkOutput("t5_ready_s1", 64'(reqReady), 64'd0);
        applyStimulus(1'b1, 5'd1, 5'd2, 1'b0, 32'h200, 64'hDEAD);
        @(negedge clk);
        checkOutput("t5_ready_s2", 64'(reqReady), 64'd0);
        applyStimulus(1'b1, 5'd1, 5'd2, 1'b0, 32'h0, 64'h0);
        @(negedge clk);
        checkOutput("t5_ready_s3", 64'(reqReady), 64'd0);
        checkOutput("t5_da", da, 64'hDEAD);
        checkOutput("t5_db", db, 64'hDEAD);
        applyStimulus(1'b1, 5'd1, 5'd2, 1'b1, 32'h0, 64'h0);
        @(negedge clk);
        checkOutput("t5_release", 64'(reqReady), 64'd1);

        // Complete with nothing behind it, then an immediate accept
        applyStimulus(1'b0, 5'd0, 5'd0, 1'b1, 32'h0, 64'h0);
        applyStimulus(1'b0, 5'd0, 5'd0, 1'b1, 32'h0, 64'h0);
        @(negedge clk);
        checkOutput("t6_idle_valid", 64'(rspValid), 64'd0);
        checkOutput("t6_hold_da", da, regs[1]);
        checkOutput("t6_hold_db", db, regs[2]);
        applyStimulus(1'b1, 5'd10, 5'd11, 1'b1, 32'h0, 64'h0);
        @(negedge clk);
        checkOutput("t6_ready", 64'(reqReady), 64'd1);
        applyStimulus(1'b0, 5'd0, 5'd0, 1'b1, 32'h0, 64'h0);
        @(negedge clk);
        checkOutput("t6_da", da, regs[10]);
        checkOutput("t6_db", db, regs[11]);

        // Reset in the middle of a stall throws the response away
        applyStimulus(1'b1, 5'd4, 5'd8, 1'b1, 32'h0, 64'h0);
        applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 32'h0, 64'h0);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("t1_rsp_valid", 64'(rspValid), 64'd0);
        checkOutput("t1_da", da, 64'd0);
        checkOutput("t1_db", db, 64'd0);
        checkOutput("t1_req_ready", 64'(reqReady), 64'd1);
        @(negedge clk);
        #3;
        reset = 1'b0;
        applyStimulus(1'b1, 5'd12, 5'd13, 1'b1, 32'h0, 64'h0);
        applyStimulus(1'b0, 5'd0, 5'd0, 1'b1, 32'h0, 64'h0);
        @(negedge clk);
        checkOutput("t1_after_da", da, regs[12]);
        checkOutput("t1_after_db", db, regs[13]);

        // Random traffic against the scoreboard
        for (int n = 0; n < 600; n++) begin
            logic        v;
            logic        rr;
            reg_addr_t   a;
            reg_addr_t   b;
            logic [31:0] w;
            reg_word_t   wd;
            v  = ($urandom_range(0, 9) < 7);
            rr = ($urandom_range(0, 9) < 6);
            a  = ($urandom_range(0, 7) == 0) ? 5'd31 : reg_addr_t'($urandom_range(0, 31));
            b  = ($urandom_range(0, 4) == 0) ? a : reg_addr_t'($urandom_range(0, 31));
            wd = {$urandom, $urandom};
            case ($urandom_range(0, 9))
                0, 1, 2, 3: w = 32'h0;
                4, 5:       w = 32'h1 << a;
                6, 7:       w = 32'h1 << $urandom_range(0, 31);
                default:    w = $urandom;
            endcase
            applyStimulus(v, a, b, rr, w, wd);
        end

        for (int n = 0; n < 4; n++) applyStimulus(1'b0, 5'd0, 5'd0, 1'b1, 32'h0, 64'h0);
        @(negedge clk);
        #2;
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
